icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Tag/valid store and miss-refill sequencer for the direct-mapped instruction cache feeding the fetch stage.
- Each cycle it decides hit or miss for the fetch address. On a miss it stalls fetch, reads one cache line from the memory port in order, writes the cache data array word by word, then validates the line.
- Also handles whole-cache invalidation (fence.i) requested by later pipeline stages.

Parameters:
NUM_LINES, 16, number of cache lines; power of 2, >=2
LINE_WORDS, 4, 32-bit words per line; power of 2, >=2
- IB = log2(NUM_LINES), WB = log2(LINE_WORDS).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch lookup valid this cycle
f_addr  in  32  fetch byte address; bits [1:0] ignored
f_hit  out  1  combinational: f_req & valid[idx] & tag match & state==IDLE
f_stall  out  1  combinational: (state==IDLE & f_req & !f_hit) | state!=IDLE
flush  in  1  invalidate entire cache (one-cycle pulse)
mem_req  out  1  line read request; held until mem_ack
mem_addr  out  32  line base address (word and byte bits zero)
mem_ack  in  1  memory accepted request this cycle
mem_rvalid  in  1  one returned word valid
mem_rdata  in  32  returned word
dw_en  out  1  data-array write enable
dw_index  out  IB  data-array line index
dw_word  out  WB  data-array word within line
dw_data  out  32  data-array write data
busy  out  1  state != IDLE

Behaviour:
- Address split: word = f_addr[WB+1:2]; idx = f_addr[WB+IB+1:WB+2]; tag = f_addr[31:WB+IB+2].
- Reset (synchronous, overrides all):
  - state=IDLE; all valid bits 0; word counter 0; pending_flush 0.
  - mem_req, dw_en, busy = 0; mem_addr = 0.
  - Tag contents don't-care.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE:
  - Hit: no state change; zero stall cycles.
  - Miss (f_req & !f_hit & !flush):
    - Latch miss_idx, miss_tag; mem_addr <= {f_addr[31:WB+2], zeros}.
    - Next state REQ.
  - flush in IDLE:
    - All valid bits cleared at the clock edge.
    - A simultaneous miss is not started; fetch re-presents next cycle and misses.
- REQ:
  - mem_req=1; mem_addr stable.
  - mem_ack=0: stay in REQ.
  - mem_ack=1: go to FILL; counter=0.
- FILL:
  - Each cycle mem_rvalid=1: dw_en=1, dw_index=miss_idx, dw_word=counter, dw_data=mem_rdata (combinational pass-through); counter++.
  - Cycles with mem_rvalid=0: dw_en=0; no progress.
  - Last word (counter==LINE_WORDS-1 with rvalid): tag[miss_idx] <= miss_tag; go to DONE.
  - Words arrive strictly in address order, word 0 first.
- DONE (one cycle):
  - If pending_flush=0: valid[miss_idx] <= 1.
  - If pending_flush=1: clear all valid bits, miss line included; pending_flush <= 0.
  - Next state IDLE; fetch retries and hits (or misses again after a flush).
- flush while busy: sets pending_flush; applied in DONE as above; never aborts the memory transaction.
- mem_ack/mem_rvalid outside REQ/FILL: ignored; no state change, no dw_en.
- Wrap-around: counter width WB; it is not used after the last word, so no wrap hazard.
- f_stall stays 1 through REQ, FILL and DONE regardless of f_req.
- Minimum miss penalty (ack in first REQ cycle, rvalid every cycle): stall covers LINE_WORDS+3 cycles (miss cycle, REQ, LINE_WORDS FILL, DONE). The hit occurs on the following cycle.
- Reset mid-REQ/FILL: returns to IDLE immediately and drops mem_req. Any late mem_rvalid is ignored.

Test Plan:
- Cold miss, defaults, f_addr=0x00000048, ack immediate, rvalid every cycle:
  - mem_req=1 with mem_addr=0x40 one cycle after miss.
  - dw writes at dw_index=4, dw_word 0..3 in consecutive cycles.
  - f_stall high 7 cycles; f_hit=1 on cycle 8.
- Hit latency:
  - After refill of 0x40, addresses 0x40, 0x44, 0x4C on consecutive cycles -> f_hit=1, f_stall=0 each cycle, no mem_req.
- Conflict miss:
  - 0x40 valid, then f_addr=0x140 (same idx 4, tag 1 vs 0) -> miss and refill.
  - Afterwards 0x40 misses again.
- Flush:
  - flush pulse in IDLE -> next access to 0x40 misses.
  - flush pulse during FILL word 1 -> refill completes with all 4 writes; 0x40 still misses after DONE.
- Handshake stalls:
  - mem_ack delayed 5 cycles -> mem_req and mem_addr held constant.
  - rvalid gaps (pattern 1,0,0,1,1,0,1) -> exactly 4 dw_en pulses, word order 0..3.
- Reset mid-FILL after 2 words:
  - Next cycle state IDLE, mem_req=0, busy=0.
  - Stray mem_rvalid -> no dw_en.
  - 0x40 misses.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Tag/valid store and in-order miss-refill sequencer for a direct-mapped instruction cache.
// Hit/stall are combinational; refill walks REQ -> FILL -> DONE, with fence.i flush support.
module icache_refill_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    localparam int IB = $clog2(NUM_LINES),
    localparam int WB = $clog2(LINE_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_hit,
    output logic          f_stall,
    input  logic          flush,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic          mem_ack,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          dw_en,
    output logic [IB-1:0] dw_index,
    output logic [WB-1:0] dw_word,
    output logic [31:0]   dw_data,
    output logic          busy
);

    localparam int TW = 32 - IB - WB - 2;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TW-1:0]         tag_q [NUM_LINES];
    logic [TW-1:0]         tag_d [NUM_LINES];
    logic [IB-1:0]         miss_idx_q, miss_idx_d;
    logic [TW-1:0]         miss_tag_q, miss_tag_d;
    logic [WB-1:0]         cnt_q, cnt_d;
    logic                  pend_flush_q, pend_flush_d;
    logic [31:0]           mem_addr_q, mem_addr_d;

    logic [IB-1:0]         f_idx_s;
    logic [TW-1:0]         f_tag_s;
    logic                  unused_addr_bits_s;

    assign f_idx_s            = f_addr[WB+IB+1:WB+2];
    assign f_tag_s            = f_addr[31:WB+IB+2];
    assign unused_addr_bits_s = ^f_addr[WB+1:0];

    // Lookup and fetch-facing handshake.
    always_comb begin
        f_hit   = f_req & valid_q[f_idx_s] & (tag_q[f_idx_s] == f_tag_s) & (state_q == S_IDLE);
        f_stall = (state_q != S_IDLE) | (f_req & ~f_hit);
    end

    // Memory and data-array outputs; reset masks the strobes in the reset cycle itself.
    always_comb begin
        busy     = (state_q != S_IDLE);
        mem_req  = (state_q == S_REQ) & ~reset;
        mem_addr = mem_addr_q;
        dw_en    = (state_q == S_FILL) & mem_rvalid & ~reset;
        dw_index = miss_idx_q;
        dw_word  = cnt_q;
        dw_data  = mem_rdata;
    end

    // Next-state logic for the refill sequencer and the tag/valid store.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        cnt_d        = cnt_q;
        pend_flush_d = pend_flush_q;
        mem_addr_d   = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    // A miss coinciding with flush is dropped; fetch re-presents it.
                    valid_d = {NUM_LINES{1'b0}};
                end else if (f_req && !f_hit) begin
                    miss_idx_d = f_idx_s;
                    miss_tag_d = f_tag_s;
                    mem_addr_d = {f_addr[31:WB+2], {(WB+2){1'b0}}};
                    state_d    = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush) begin
                    pend_flush_d = 1'b1;
                end else begin
                    pend_flush_d = pend_flush_q;
                end
                if (mem_ack) begin
                    cnt_d   = {WB{1'b0}};
                    state_d = S_FILL;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FILL: begin
                if (flush) begin
                    pend_flush_d = 1'b1;
                end else begin
                    pend_flush_d = pend_flush_q;
                end
                if (mem_rvalid) begin
                    cnt_d = cnt_q + WB'(1);
                    if (cnt_q == LAST_WORD) begin
                        tag_d[miss_idx_q] = miss_tag_q;
                        state_d           = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE: begin
                // A flush seen during the refill (or right now) wins over validating the line.
                if (pend_flush_q || flush) begin
                    valid_d = {NUM_LINES{1'b0}};
                end else begin
                    valid_d[miss_idx_q] = 1'b1;
                end
                pend_flush_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, valid bits and refill bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= {NUM_LINES{1'b0}};
            miss_idx_q   <= {IB{1'b0}};
            miss_tag_q   <= {TW{1'b0}};
            cnt_q        <= {WB{1'b0}};
            pend_flush_q <= 1'b0;
            mem_addr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_idx_q   <= miss_idx_d;
            miss_tag_q   <= miss_tag_d;
            cnt_q        <= cnt_d;
            pend_flush_q <= pend_flush_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Tag storage carries no reset; entries are qualified by valid_q.
    always_ff @(posedge clock) begin
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: table of IDLE lookups, refill sequences,
// and a scoreboard queue of expected data-array writes popped by a dw_en monitor.
module tb_icache_refill_ctrl;

    localparam int NL = 16;
    localparam int LW = 4;
    localparam int IB = 4;
    localparam int WB = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_hit;
    logic          f_stall;
    logic          flush;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          dw_en;
    logic [IB-1:0] dw_index;
    logic [WB-1:0] dw_word;
    logic [31:0]   dw_data;
    logic          busy;

    icache_refill_ctrl #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clock      (clock),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_hit      (f_hit),
        .f_stall    (f_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .dw_en      (dw_en),
        .dw_index   (dw_index),
        .dw_word    (dw_word),
        .dw_data    (dw_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IB-1:0] idx;
        logic [WB-1:0] word;
        logic [31:0]   data;
    } dw_exp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        fl;
        logic        hit;
        logic        stall;
    } vec_t;

    dw_exp_t sb_q[$];
    dw_exp_t mon_e;
    vec_t    vt[8];
    int      n_pass = 0;
    int      n_chk  = 0;
    int      dw_cnt = 0;
    int      sc;
    int      dw0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every data-array write must match the oldest expected write.
    always @(negedge clock) begin
        if (dw_en === 1'b1) begin
            dw_cnt++;
            if (sb_q.size() == 0) begin
                chk("dw_unexpected", {31'd0, dw_en}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("dw_index", 32'(dw_index), 32'(mon_e.idx));
                chk("dw_word",  32'(dw_word),  32'(mon_e.word));
                chk("dw_data",  dw_data,       mon_e.data);
            end
        end
    end

    // Full miss/refill: ack after ack_dly extra cycles, rvalid per pattern (LSB first, then 1s),
    // optional flush on the cycle that writes word flush_word.
    task automatic miss_refill(input logic [31:0] addr, input int ack_dly, input logic [15:0] pat,
                               input int pat_len, input int flush_word, output int stall_cnt);
        logic [31:0]   base;
        logic [IB-1:0] idx;
        int            words;
        int            cyc;
        bit            flushed;
        base      = addr & 32'hFFFF_FFF0;
        idx       = addr[WB+IB+1:WB+2];
        words     = 0;
        cyc       = 0;
        flushed   = 1'b0;
        stall_cnt = 0;

        f_req = 1'b1; f_addr = addr; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        chk("miss_hit", f_hit, 0);
        chk("miss_stall", f_stall, 1);
        chk("miss_busy", busy, 0);
        chk("miss_mem_req", mem_req, 0);
        if (f_stall) stall_cnt++;
        tick();

        for (int d = 0; d <= ack_dly; d++) begin
            mem_ack = (d == ack_dly);
            @(negedge clock);
            chk("req_mem_req", mem_req, 1);
            chk("req_mem_addr", mem_addr, base);
            chk("req_stall", f_stall, 1);
            if (f_stall) stall_cnt++;
            tick();
        end
        mem_ack = 1'b0;

        while (words < LW && cyc < 64) begin
            mem_rvalid = (cyc < pat_len) ? pat[cyc] : 1'b1;
            mem_rdata  = mem_rvalid ? mem_model(base + 32'(words * 4)) : 32'hDEAD_BEEF;
            flush      = mem_rvalid && (words == flush_word);
            if (flush) flushed = 1'b1;
            if (mem_rvalid) begin
                sb_q.push_back('{idx: idx, word: WB'(words), data: mem_rdata});
                words++;
            end
            @(negedge clock);
            chk("fill_mem_req", mem_req, 0);
            chk("fill_stall", f_stall, 1);
            if (f_stall) stall_cnt++;
            tick();
            cyc++;
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;

        @(negedge clock);
        chk("done_busy", busy, 1);
        chk("done_stall", f_stall, 1);
        chk("sb_drained", sb_q.size(), 0);
        if (f_stall) stall_cnt++;
        tick();
        chk("stall_cycles", stall_cnt, 1 + (ack_dly + 1) + cyc + 1);

        // Retry; a flushed refill must miss again (flush held so no new miss starts).
        f_req = 1'b1; f_addr = addr; flush = flushed;
        @(negedge clock);
        chk("retry_hit", f_hit, !flushed);
        chk("retry_stall", f_stall, flushed);
        chk("retry_busy", busy, 0);
        tick();
        f_req = 1'b0; flush = 1'b0;
        @(negedge clock);
        chk("idle_after", busy, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = '{req: 1'b1, addr: 32'h40, fl: 1'b0, hit: 1'b1, stall: 1'b0};
        vt[1] = '{req: 1'b1, addr: 32'h44, fl: 1'b0, hit: 1'b1, stall: 1'b0};
        vt[2] = '{req: 1'b1, addr: 32'h4C, fl: 1'b0, hit: 1'b1, stall: 1'b0};
        vt[3] = '{req: 1'b0, addr: 32'h40, fl: 1'b0, hit: 1'b0, stall: 1'b0};
        vt[4] = '{req: 1'b1, addr: 32'h50, fl: 1'b1, hit: 1'b0, stall: 1'b1};
        vt[5] = '{req: 1'b0, addr: 32'h0,  fl: 1'b0, hit: 1'b0, stall: 1'b0};
        vt[6] = '{req: 1'b1, addr: 32'h40, fl: 1'b1, hit: 1'b0, stall: 1'b1};
        vt[7] = '{req: 1'b0, addr: 32'h0,  fl: 1'b0, hit: 1'b0, stall: 1'b0};

        reset = 1'b1; f_req = 1'b0; f_addr = 32'd0; flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick();
        mem_ack = 1'b1; mem_rvalid = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_dw_en", dw_en, 0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_mem_req", mem_req, 0);
        chk("idle_stray_dw_en", dw_en, 0);
        chk("idle_stall", f_stall, 0);
        tick();
        mem_rvalid = 1'b0;

        // Cold miss at 0x48: line 0x40, index 4, 7 stall cycles.
        miss_refill(32'h48, 0, 16'h0, 0, -1, sc);
        chk("cold_stall_cycles", sc, 7);

        // IDLE lookup table: hits, idle, flush-with-miss, flush clearing 0x40.
        for (int i = 0; i < 8; i++) begin
            f_req = vt[i].req; f_addr = vt[i].addr; flush = vt[i].fl;
            @(negedge clock);
            chk($sformatf("vec%0d_hit", i), f_hit, vt[i].hit);
            chk($sformatf("vec%0d_stall", i), f_stall, vt[i].stall);
            chk($sformatf("vec%0d_mem_req", i), mem_req, 0);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            tick();
        end
        f_req = 1'b0; flush = 1'b0;

        // Delayed ack and rvalid gaps 1,0,0,1,1,0,1.
        dw0 = dw_cnt;
        miss_refill(32'h40, 5, 16'b1011001, 7, -1, sc);
        chk("gap_dw_pulses", dw_cnt - dw0, 4);

        // Conflict: 0x140 evicts 0x40, which then misses again.
        miss_refill(32'h140, 0, 16'h0, 0, -1, sc);
        miss_refill(32'h40, 0, 16'h0, 0, -1, sc);

        // Flush in IDLE, then flush during FILL word 1.
        flush = 1'b1;
        @(negedge clock);
        chk("flush_idle_busy", busy, 0);
        tick();
        flush = 1'b0;
        dw0 = dw_cnt;
        miss_refill(32'h40, 0, 16'h0, 0, 1, sc);
        chk("flush_fill_dw_pulses", dw_cnt - dw0, 4);

        // Reset in FILL after two words.
        f_req = 1'b1; f_addr = 32'h40;
        @(negedge clock);
        chk("rf_miss_stall", f_stall, 1);
        tick();
        f_req = 1'b0; mem_ack = 1'b1;
        @(negedge clock);
        chk("rf_req", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        for (int w = 0; w < 2; w++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model(32'h40 + 32'(w * 4));
            sb_q.push_back('{idx: 4'd4, word: WB'(w), data: mem_rdata});
            @(negedge clock);
            chk("rf_fill_busy", busy, 1);
            tick();
        end
        reset = 1'b1; mem_rvalid = 1'b0;
        @(negedge clock);
        chk("rf_rst_mem_req", mem_req, 0);
        tick();
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
        @(negedge clock);
        chk("rf_busy", busy, 0);
        chk("rf_mem_req", mem_req, 0);
        chk("rf_stray_dw_en", dw_en, 0);
        chk("rf_mem_addr", mem_addr, 32'd0);
        chk("rf_stall", f_stall, 0);
        tick();
        mem_rvalid = 1'b0;
        miss_refill(32'h40, 0, 16'h0, 0, -1, sc);

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
